// File: rtl/ram2_arbiter_if.sv
// Requester-side bundle for ram2_arbiter: two req/ack ports plus the shared read data and busy flag.
// master = requester side (testbench or client logic), slave = the arbiter.
interface ram2_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              a_req;
    logic              b_req;
    logic              a_we;
    logic              b_we;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] a_wdata;
    logic [DATA_W-1:0] b_wdata;
    logic              a_ack;
    logic              b_ack;
    logic [DATA_W-1:0] rdata;
    logic              busy;

    modport master (
        output a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata,
        input  a_ack, b_ack, rdata, busy
    );

    modport slave (
        input  a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata,
        output a_ack, b_ack, rdata, busy
    );
endinterface

// File: rtl/ram2_arbiter.sv
// Round-robin arbiter giving two requesters access to one single-port RAM with a bidirectional data bus.
// Optional RAM_ARB_CLEAR_EN: zero-fill the whole RAM after every reset before serving requests.
//
// Handshake: a requester raises req (with we/addr/wdata valid) and holds it until its ack, a single-cycle
// pulse. Inputs are latched in IDLE, so later changes do not disturb the access in progress. A req still
// high in the IDLE cycle after its ack counts as a new request.
module ram2_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    ram2_arbiter_if.slave     req,
    output logic              ram_ena,
    output logic              ram_wena,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data,
    output logic [2:0]        dbg_state
);

`ifdef RAM_ARB_CLEAR_EN
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ACCESS  = 3'd1,
        S_CAPTURE = 3'd2,
        S_DONE    = 3'd3,
        S_CLEAR   = 3'd4
    } state_t;
    localparam state_t RESET_STATE = S_CLEAR;
`else
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ACCESS  = 3'd1,
        S_CAPTURE = 3'd2,
        S_DONE    = 3'd3
    } state_t;
    localparam state_t RESET_STATE = S_IDLE;
`endif

    state_t            state_q, state_d;
    logic              grant_q, grant_d;   // 0 = A, 1 = B
    logic              last_q, last_d;     // requester granted most recently
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              pick_b;
    logic              drive_en;
    logic [DATA_W-1:0] drive_val;
    logic              a_ack, b_ack;
`ifdef RAM_ARB_CLEAR_EN
    logic [ADDR_W-1:0] clr_q, clr_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_STATE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef RAM_ARB_CLEAR_EN
            clr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef RAM_ARB_CLEAR_EN
            clr_q   <= clr_d;
`endif
        end
    end

    // With both requesting, the one not granted last wins; otherwise whoever is asking.
    assign pick_b = (req.a_req && req.b_req) ? ~last_q : ~req.a_req;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        ram_ena   = 1'b0;
        ram_wena  = 1'b0;
        ram_addr  = addr_q;
        drive_en  = 1'b0;
        drive_val = wdata_q;
        a_ack     = 1'b0;
        b_ack     = 1'b0;
`ifdef RAM_ARB_CLEAR_EN
        clr_d     = clr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req.a_req || req.b_req) begin
                    grant_d = pick_b;
                    last_d  = pick_b;
                    we_d    = pick_b ? req.b_we    : req.a_we;
                    addr_d  = pick_b ? req.b_addr  : req.a_addr;
                    wdata_d = pick_b ? req.b_wdata : req.a_wdata;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                ram_ena  = 1'b1;
                ram_wena = we_q;
                drive_en = we_q;
                state_d  = we_q ? S_DONE : S_CAPTURE;
            end
            S_CAPTURE: begin
                ram_ena = 1'b1;
                rdata_d = ram_data;
                state_d = S_DONE;
            end
            S_DONE: begin
                a_ack   = ~grant_q;
                b_ack   = grant_q;
                state_d = S_IDLE;
            end
`ifdef RAM_ARB_CLEAR_EN
            S_CLEAR: begin
                ram_ena   = 1'b1;
                ram_wena  = 1'b1;
                ram_addr  = clr_q;
                drive_en  = 1'b1;
                drive_val = '0;
                clr_d     = clr_q + 1'b1;
                if (clr_q == {ADDR_W{1'b1}}) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // The arbiter only drives the bus while writing, so it never fights the RAM's read data.
    assign ram_data  = drive_en ? drive_val : {DATA_W{1'bz}};

    assign req.a_ack = a_ack;
    assign req.b_ack = b_ack;
    assign req.rdata = rdata_q;
    assign req.busy  = (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule

// File: doc/ram2_arbiter.md
RAM2_ARBITER -- requirements
Module: ram2_arbiter

Interface
REQ-001 Parameter ADDR_W, default 5, RAM address width (32 words).
REQ-002 Parameter DATA_W, default 32, RAM word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 a_req, b_req  input  1 each  access request from requester A / B; held high until matching ack.
REQ-006 a_we, b_we  input  1 each  1 = write, 0 = read; valid while req high.
REQ-007 a_addr, b_addr  input  ADDR_W each  target word address.
REQ-008 a_wdata, b_wdata  input  DATA_W each  write data.
REQ-009 a_ack, b_ack  output  1 each  one-cycle completion pulse.
REQ-010 rdata  output  DATA_W  last read word, shared by both requesters.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 ram_ena, ram_wena  output  1 each  RAM enable and write enable.
REQ-013 ram_addr  output  ADDR_W  RAM address.
REQ-014 ram_data  inout  DATA_W  bidirectional RAM data bus.

Function
REQ-015 FSM states SHALL be IDLE, ACCESS, CAPTURE, DONE, plus CLEAR when RAM_ARB_CLEAR_EN is defined.
REQ-016 IDLE: ram_ena=0, ram_data=Z; on any req high, latch grant, we, addr and wdata, then go to ACCESS.
REQ-017 Arbitration SHALL be round-robin: with one req high, grant it; with both high, grant the requester not granted last.
REQ-018 Last-grant register SHALL reset to B, so A wins the first simultaneous request.
REQ-019 ACCESS (1 cycle): ram_ena=1, ram_wena=latched we, ram_addr=latched addr; ram_data driven with latched wdata only if we=1; next state DONE if write, CAPTURE if read.
REQ-020 CAPTURE (1 cycle): ram_ena=1, ram_wena=0, ram_addr held, ram_data=Z; rdata loaded from ram_data at the end of the cycle; next DONE.
REQ-021 DONE (1 cycle): ram_ena=0, ack of the granted requester=1, other ack=0; next IDLE.
REQ-022 Latency: req seen in IDLE at edge n -> write ack in cycle n+2, read ack in cycle n+3 with rdata already valid.
REQ-023 rdata SHALL hold its value until the next CAPTURE; writes do not change it.
REQ-024 ram_data SHALL be driven only during ACCESS with we=1, or during CLEAR; it is Z in every other state, so bus contention with the RAM is impossible.
REQ-025 A req still high in the IDLE cycle after its ack is a new request; requesters drop req on ack to avoid a repeat.
REQ-026 Requests arriving while busy are not lost; they are arbitrated in the next IDLE cycle.
REQ-027 Requests from the non-granted requester and changes to inputs after latch SHALL NOT affect the access in progress.

Reset
REQ-028 On rst=1 at a clock edge: state to IDLE (or CLEAR if enabled), acks=0, ram_ena=0, ram_wena=0, ram_addr=0, rdata=0, last-grant=B, ram_data=Z.
REQ-029 Reset mid-access SHALL abort it with no ack issued; rst dominates all other inputs.

Configuration
REQ-030 Macro RAM_ARB_CLEAR_EN defined: after reset, CLEAR state writes 0 to addresses 0..31 in order, one per cycle (ram_ena=1, ram_wena=1), with busy=1, no acks and requests pending; then IDLE.
REQ-031 RAM_ARB_CLEAR_EN undefined: no CLEAR state; IDLE directly after reset; RAM contents untouched.

Verification
REQ-032 A write addr 5'h15 data 32'hDEADBEEF -> ram_ena=1, ram_wena=1 and bus=DEADBEEF in cycle n+1; a_ack in cycle n+2.
REQ-033 A read addr 5'h15 after the previous write -> ram_data Z from the arbiter in ACCESS/CAPTURE; a_ack in n+3 with rdata=32'hDEADBEEF.
REQ-034 a_req and b_req high together from reset, held -> grants alternate A,B,A,B; each ack a single cycle.
REQ-035 rst asserted during CAPTURE of a B read -> next cycle IDLE, b_ack never pulses, rdata=0, bus Z.
REQ-036 With RAM_ARB_CLEAR_EN: busy=1 for 32 cycles after reset, addresses 0..31 written with 0; a read of 5'h0B after that returns 0; a req raised during CLEAR is served after it.
